pipe_stage_elastic: RTL and testbench

Generic, parametrised pipeline stage register that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload with a valid/ready handshake, synchronous flush and a 2-entry skid buffer. The skid buffer gives full throughput with no combinational path from out_ready to in_ready. Stages are instantiated back-to-back between pipeline phases of the core.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_slot.sv | 24 ++
 rtl/pipe_stage_elastic.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// Optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 18;

    // Encoding doubles as the occupancy count driven on the occupancy port.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam logic [1:0]  OCC_EMPTY = 2'd0;
    localparam logic [1:0]  OCC_ONE   = 2'd1;
    localparam logic [1:0]  OCC_TWO   = 2'd2;

    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

endpackage

// File: rtl/pipe_slot.sv
// Single payload register with load enable; cleared to 0 by asynchronous active-low reset.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Define PIPE_STAGE_STATS_EN to add saturating stall/bubble cycle counters.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned CTRL_W   = CTRL_W_DEF,
    parameter int unsigned KILL_BIT = 0
) (
    input  logic              clk_i,
    input  logic              async_reset_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_pc_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic              flush_i,
`ifdef PIPE_STAGE_STATS_EN
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       bubble_cnt_o,
`endif
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o
);

    localparam int unsigned PW = DATA_W + ADDR_W + CTRL_W;

    pipe_state_e   st_q, st_d;
    logic          in_ready_q, out_valid_q;
    logic          accept, take;
    logic          main_load, skid_load;
    logic [PW-1:0] in_payload, main_d, main_q, skid_q;

    assign in_payload = {in_ctrl_i, in_pc_i, in_data_i};
    assign accept     = in_valid_i & in_ready_q;
    assign take       = out_valid_q & out_ready_i;

    always_comb begin
        st_d      = st_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_payload;
        if (flush_i) begin
            st_d = ST_EMPTY;
        end else begin
            unique case (st_q)
                ST_EMPTY: begin
                    if (accept) begin
                        st_d      = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && take) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        st_d      = ST_TWO;
                        skid_load = 1'b1;
                    end else if (take) begin
                        st_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        st_d      = ST_ONE;
                        main_load = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: st_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags come from the next state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk_i or negedge async_reset_ni) begin
        if (!async_reset_ni) begin
            st_q        <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            in_ready_q  <= (st_d != ST_TWO);
            out_valid_q <= (st_d != ST_EMPTY);
        end
    end

    pipe_slot #(
        .W (PW)
    ) u_main (
        .clk_i  (clk_i),
        .rst_ni (async_reset_ni),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_slot #(
        .W (PW)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_ni (async_reset_ni),
        .load_i (skid_load),
        .d_i    (in_payload),
        .q_o    (skid_q)
    );

    always_comb begin
        out_ctrl_o           = main_q[DATA_W+ADDR_W +: CTRL_W];
        // A bubble must never carry the register-write enable.
        out_ctrl_o[KILL_BIT] = main_q[DATA_W+ADDR_W+KILL_BIT] & out_valid_q;
    end

    assign out_data_o  = main_q[DATA_W-1:0];
    assign out_pc_o    = main_q[DATA_W +: ADDR_W];
    assign out_valid_o = out_valid_q;
    assign in_ready_o  = in_ready_q;
    assign occupancy_o = st_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_q, stall_d, bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (flush_i) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (out_valid_q && !out_ready_i && (stall_q != CNT_MAX)) begin
                stall_d = stall_q + 16'd1;
            end
            if (!out_valid_q && out_ready_i && (bubble_q != CNT_MAX)) begin
                bubble_d = bubble_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_reset_ni) begin
        if (!async_reset_ni) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: vector table, corner sequences, random scoreboard.
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 18;
    localparam int unsigned KB = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [AW-1:0] p;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        rdy;
        logic        fl;
        logic        e_rdy;
        logic        e_ov;
        logic [1:0]  e_occ;
        logic [31:0] e_od;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [AW-1:0] in_pc, out_pc;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]   stall_cnt, bubble_cnt;
`endif

    int    checks = 0;
    int    errors = 0;
    int    m_occ  = 0;
    beat_t sb[$];
    vec_t  vt[12];

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .CTRL_W   (CW),
        .KILL_BIT (KB)
    ) dut (
        .clk_i          (clk),
        .async_reset_ni (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_pc_i        (in_pc),
        .in_ctrl_i      (in_ctrl),
        .flush_i        (flush),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt_o    (stall_cnt),
        .bubble_cnt_o   (bubble_cnt),
`endif
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_pc_o       (out_pc),
        .out_ctrl_o     (out_ctrl),
        .occupancy_o    (occupancy)
    );

    function automatic beat_t mk(input logic [31:0] d);
        beat_t b;
        b.d     = d;
        b.p     = d * 4 + 32'h1000;
        b.c     = CW'(d ^ 32'h0002_A5A4);
        b.c[KB] = 1'b1;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive, check against the model, update model, advance one cycle.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic rdy, input logic fl,
                         input logic indep);
        beat_t b;
        logic  ac, tk, saved;
        b         = mk(d);
        in_valid  = iv;
        in_data   = b.d;
        in_pc     = b.p;
        in_ctrl   = b.c;
        out_ready = rdy;
        flush     = fl;
        #1;
        chk("occupancy", 64'(occupancy), 64'(m_occ));
        chk("in_ready", 64'(in_ready), 64'(m_occ < 2));
        chk("out_valid", 64'(out_valid), 64'(m_occ > 0));
        if (m_occ > 0) begin
            chk("out_data", 64'(out_data), 64'(sb[0].d));
            chk("out_pc", 64'(out_pc), 64'(sb[0].p));
            chk("out_ctrl", 64'(out_ctrl), 64'(sb[0].c));
        end else begin
            chk("bubble_kill_bit", 64'(out_ctrl[KB]), 64'(0));
        end
        if (indep) begin
            saved     = in_ready;
            out_ready = ~rdy;
            #1;
            chk("in_ready_vs_out_ready", 64'(in_ready), 64'(saved));
            out_ready = rdy;
        end
        if (fl) begin
            sb.delete();
            m_occ = 0;
        end else begin
            tk = rdy && (m_occ > 0);
            ac = iv && (m_occ < 2);
            if (tk) void'(sb.pop_front());
            if (ac) sb.push_back(b);
            m_occ = m_occ + int'(ac) - int'(tk);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pc     = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // iv, d, rdy, fl | expected before the edge: in_ready, out_valid, occupancy, out_data
        vt[0]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
        vt[1]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA};
        vt[2]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'hA};
        vt[3]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'hA};
        vt[4]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hB};
        vt[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hC};
        vt[6]  = '{1'b1, 32'hE,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hC};
        vt[7]  = '{1'b1, 32'hD,  1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 32'hC};
        vt[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
        vt[9]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
        vt[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11};
        vt[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};

        #12;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_occupancy", 64'(occupancy), 64'(0));
        chk("reset_out_data", 64'(out_data), 64'(0));
        chk("reset_out_pc", 64'(out_pc), 64'(0));
        chk("reset_out_ctrl", 64'(out_ctrl), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure, skid fill/drain and flush with skid full
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
            chk($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(vt[i].e_occ));
            if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vt[i].e_od));
            cycle(vt[i].iv, vt[i].d, vt[i].rdy, vt[i].fl, 1'b0);
        end

        // Streaming 1..8 back-to-back
        for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset with the skid full, off the clock edge
        cycle(1'b1, 32'h51, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h52, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_occupancy", 64'(occupancy), 64'(2));
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'(0));
        chk("async_rst_in_ready", 64'(in_ready), 64'(1));
        chk("async_rst_occupancy", 64'(occupancy), 64'(0));
        chk("async_rst_out_data", 64'(out_data), 64'(0));
        chk("async_rst_out_pc", 64'(out_pc), 64'(0));
        chk("async_rst_out_ctrl", 64'(out_ctrl), 64'(0));
        sb.delete();
        m_occ = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h60, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) == 0), 1'b1);
        end

`ifdef PIPE_STAGE_STATS_EN
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h70, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_cnt_5", 64'(stall_cnt), 64'(5));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (70000) @(negedge clk);
        chk("bubble_cnt_sat", 64'(bubble_cnt), 64'(16'hFFFF));
        chk("stall_cnt_hold", 64'(stall_cnt), 64'(5));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
